// File: rtl/pipe_pkg.sv
//==============================================================================
// Module      : pipe_pkg
// Description : Shared stall constants, stage mode enum and mode decode for
//               the inter-stage pipeline registers.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package pipe_pkg;

   localparam logic c_stop   = 1'b1;
   localparam logic c_nostop = 1'b0;

   // Payload/context widths of the classic MIPS EX/MEM and later stages
   localparam int unsigned c_mips_data_w = 146;
   localparam int unsigned c_mips_ctx_w  = 66;

   typedef enum logic [1:0] {
      MODE_FLUSH  = 2'd0,
      MODE_PASS   = 2'd1,
      MODE_BUBBLE = 2'd2,
      MODE_HOLD   = 2'd3
   } mode_e;

   // s is this stage's stall bit and n the downstream bit; flush always wins.
   // A stall with the downstream stage free means only this stage emits a bubble.
   function automatic mode_e decode_mode(input logic flush, input logic s, input logic n);
      if (flush)
         return MODE_FLUSH;
      if (s == c_nostop)
         return MODE_PASS;
      if (n == c_nostop)
         return MODE_BUBBLE;
      return MODE_HOLD;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
//==============================================================================
// Module      : pipe_sat_cnt
// Description : Up counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module pipe_sat_cnt #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (inc && !(&r_count))
         r_count <= r_count + 1'b1;
   end

   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_ctx.sv
//==============================================================================
// Module      : pipe_stage_ctx
// Description : Inter-stage register with flush/bubble/hold and a retained
//               multi-cycle context word. Counters built under PIPE_STAGE_PERF_EN.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module pipe_stage_ctx
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W    = c_mips_data_w,
   parameter int unsigned       CTX_W     = c_mips_ctx_w,
   parameter int unsigned       STALL_W   = 6,
   parameter int unsigned       STAGE_IDX = 3,
   parameter logic [DATA_W-1:0] NOP_VALUE = '0,
   parameter int unsigned       PERF_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [CTX_W-1:0]   ctx_i,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic [CTX_W-1:0]   ctx_o,
   output logic               ctx_live,
   output logic [PERF_W-1:0]  bubble_cnt,
   output logic [PERF_W-1:0]  hold_cnt
);

   typedef enum logic [0:0] {
      CTX_IDLE = 1'b0,
      CTX_LIVE = 1'b1
   } ctx_state_e;

   mode_e             w_mode;
   ctx_state_e        r_ctx_state;
   logic              r_valid;
   logic [DATA_W-1:0] r_data;
   logic [CTX_W-1:0]  r_ctx;

   assign w_mode = decode_mode(flush, stall[STAGE_IDX], stall[STAGE_IDX+1]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_data      <= NOP_VALUE;
         r_ctx       <= '0;
         r_ctx_state <= CTX_IDLE;
      end else begin
         case (w_mode)
            MODE_FLUSH: begin
               r_valid     <= 1'b0;
               r_data      <= NOP_VALUE;
               r_ctx       <= '0;
               r_ctx_state <= CTX_IDLE;
            end
            MODE_PASS: begin
               r_valid     <= in_valid;
               r_data      <= in_data;
               r_ctx       <= '0;
               r_ctx_state <= CTX_IDLE;
            end
            // Downstream keeps moving: emit a NOP but keep the partial result.
            MODE_BUBBLE: begin
               r_valid     <= 1'b0;
               r_data      <= NOP_VALUE;
               r_ctx       <= ctx_i;
               r_ctx_state <= CTX_LIVE;
            end
            MODE_HOLD: begin
               r_ctx       <= ctx_i;
               r_ctx_state <= CTX_LIVE;
            end
         endcase
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign ctx_o     = r_ctx;
   assign ctx_live  = (r_ctx_state == CTX_LIVE);

`ifdef PIPE_STAGE_PERF_EN
   pipe_sat_cnt #(
      .WIDTH (PERF_W)
   ) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_mode == MODE_BUBBLE),
      .count (bubble_cnt)
   );

   pipe_sat_cnt #(
      .WIDTH (PERF_W)
   ) u_hold_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_mode == MODE_HOLD),
      .count (hold_cnt)
   );
`else
   assign bubble_cnt = '0;
   assign hold_cnt   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_ctx.sv
//==============================================================================
// Module      : tb_pipe_stage_ctx
// Description : Scoreboard bench for pipe_stage_ctx (STAGE_IDX 3, PERF_W 4).
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_pipe_stage_ctx;

   localparam int DW = 146;
   localparam int CW = 66;
   localparam int PW = 4;

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      logic          l;
      logic [PW-1:0] b;
      logic [PW-1:0] h;
      string         name;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [5:0]    stall = '0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] ctx_i = '0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [CW-1:0] ctx_o;
   logic          ctx_live;
   logic [PW-1:0] bubble_cnt;
   logic [PW-1:0] hold_cnt;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   pipe_stage_ctx #(
      .DATA_W    (DW),
      .CTX_W     (CW),
      .STALL_W   (6),
      .STAGE_IDX (3),
      .NOP_VALUE ('0),
      .PERF_W    (PW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .ctx_i      (ctx_i),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .ctx_o      (ctx_o),
      .ctx_live   (ctx_live),
      .bubble_cnt (bubble_cnt),
      .hold_cnt   (hold_cnt)
   );

   always #5 clk = ~clk;

   // Counter expectation: the real value when counters are built, else 0.
   function automatic logic [PW-1:0] pc(input int v);
`ifdef PIPE_STAGE_PERF_EN
      logic [PW-1:0] t;
      t = v[PW-1:0];
      return t;
`else
      return '0;
`endif
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic check_all(input string name, input exp_t e);
      check({name, ".valid"}, DW'(out_valid), DW'(e.v));
      check({name, ".data"},  out_data, e.d);
      check({name, ".ctx"},   DW'(ctx_o), DW'(e.c));
      check({name, ".live"},  DW'(ctx_live), DW'(e.l));
      check({name, ".bcnt"},  DW'(bubble_cnt), DW'(e.b));
      check({name, ".hcnt"},  DW'(hold_cnt), DW'(e.h));
   endtask

   task automatic step(input string name, input logic [5:0] st, input logic fl,
                       input logic iv, input logic [DW-1:0] id, input logic [CW-1:0] ci,
                       input logic ev, input logic [DW-1:0] ed, input logic [CW-1:0] ec,
                       input logic el, input int eb, input int eh);
      exp_t e;
      @(negedge clk);
      stall    = st;
      flush    = fl;
      in_valid = iv;
      in_data  = id;
      ctx_i    = ci;
      e.v = ev; e.d = ed; e.c = ec; e.l = el;
      e.b = pc(eb); e.h = pc(eh); e.name = name;
      exp_q.push_back(e);
   endtask

   // Monitor: outputs are compared just after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_all(e.name, e);
         end
      end
   end

   initial begin
      exp_t z;
      logic [DW-1:0] ab;
      int bexp;
      z.v = 1'b0; z.d = '0; z.c = '0; z.l = 1'b0; z.b = '0; z.h = '0; z.name = "zero";
      ab = {2'b10, {18{8'hAB}}};

      #2;
      check_all("por", z);
      @(negedge clk);
      rst = 1'b0;

      step("fill_ab", 6'b000000, 0, 1, ab, '0, 1, ab, '0, 0, 0, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all("async_rst", z);
      @(negedge clk);
      rst = 1'b0;

      step("pass",   6'b000000, 0, 1, DW'('h1234), CW'('h9), 1, DW'('h1234), '0, 0, 0, 0);
      step("bub1",   6'b001000, 0, 1, DW'('hdead), CW'('h1), 0, '0, CW'('h1), 1, 1, 0);
      step("bub2",   6'b001000, 0, 1, DW'('hdead), CW'('h2), 0, '0, CW'('h2), 1, 2, 0);
      step("pass55", 6'b000000, 0, 1, DW'('h55), CW'('h7), 1, DW'('h55), '0, 0, 2, 0);
      step("hold1",  6'b011000, 0, 0, DW'('h99), CW'('h10), 1, DW'('h55), CW'('h10), 1, 2, 1);
      step("hold2",  6'b011000, 0, 0, DW'('h99), CW'('h11), 1, DW'('h55), CW'('h11), 1, 2, 2);
      step("hold3",  6'b011000, 0, 1, DW'('h99), {CW{1'b1}}, 1, DW'('h55), {CW{1'b1}}, 1, 2, 3);
      step("fl_hold", 6'b011000, 1, 1, DW'('h99), CW'('h33), 0, '0, '0, 0, 2, 3);
      step("s0_n1",  6'b010000, 0, 1, DW'('h77), CW'('h44), 1, DW'('h77), '0, 0, 2, 3);
      step("fl_only", 6'b000000, 1, 1, DW'('h88), CW'('h45), 0, '0, '0, 0, 2, 3);
      step("pass_inv", 6'b000000, 0, 0, DW'('h66), CW'('h46), 0, DW'('h66), '0, 0, 2, 3);
      for (int k = 1; k <= 20; k++) begin
         bexp = (2 + k > 15) ? 15 : 2 + k;
         step("bub_sat", 6'b001000, 0, 1, DW'('h5a), CW'(k), 0, '0, CW'(k), 1, bexp, 3);
      end
      step("final", 6'b000000, 0, 1, ab, CW'('h3), 1, ab, '0, 0, 15, 3);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(posedge clk);
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_stage_ctx.md
# pipe_stage_ctx

Parametrised inter-stage pipeline register that generalises the per-stage latches between EX/MEM and later stages. It captures an arbitrary-width payload plus a valid bit and decodes the shared stall vector for its own stage index. On a stall it either inserts a bubble or holds, and it adds a flush input. It carries a feedback context word so a multi-cycle execute unit (HI/LO accumulators, iteration counter) keeps its partial state while the stage is stalled.

## Interface
- DATA_W, 146 — payload width (wdata, wd, wreg, hi, lo, whilo, aluop, mem_addr, reg2 concatenated by the instantiator)
- CTX_W, 66 — multi-cycle context width (64-bit HI/LO partial plus 2-bit count)
- STALL_W, 6 — stall vector width
- STAGE_IDX, 3 — index of this register's own bit in `stall`; the downstream bit is STAGE_IDX+1; must satisfy STAGE_IDX < STALL_W-1
- NOP_VALUE, {DATA_W{1'b0}} — payload value driven for bubbles and flushes
- PERF_W, 32 — width of the performance counters

Ports:
- clk  in  1  — single clock, rising edge
- rst  in  1  — asynchronous, active-high reset
- stall  in  STALL_W  — 1 = Stop, 0 = NoStop
- flush  in  1  — kill the stage contents
- in_valid  in  1  — upstream slot holds a real instruction
- in_data  in  DATA_W  — upstream payload
- ctx_i  in  CTX_W  — context produced by the execute unit this cycle
- out_valid  out  1  — registered valid
- out_data  out  DATA_W  — registered payload
- ctx_o  out  CTX_W  — registered context fed back to the execute unit
- ctx_live  out  1  — ctx_o holds a retained partial result
- bubble_cnt  out  PERF_W  — bubbles inserted (saturating)
- hold_cnt  out  PERF_W  — cycles held (saturating)

## Operation
- Let S = stall[STAGE_IDX] and N = stall[STAGE_IDX+1]. Each clock edge applies exactly one mode, highest priority first:
  - FLUSH (flush = 1): out_valid = 0; out_data = NOP_VALUE; ctx_o = 0; ctx_live = 0.
  - PASS (S = 0): out_valid = in_valid; out_data = in_data; ctx_o = 0; ctx_live = 0.
  - BUBBLE (S = 1, N = 0): out_valid = 0; out_data = NOP_VALUE (the entire payload, including memory fields); ctx_o = ctx_i; ctx_live = 1.
  - HOLD (S = 1, N = 1): out_valid and out_data are unchanged; ctx_o = ctx_i; ctx_live = 1.
- Reset: out_valid = 0, out_data = NOP_VALUE, ctx_o = 0, ctx_live = 0, and both counters = 0. Reset acts immediately, independent of clk, and overrides everything, including a multi-cycle operation already in flight.
- ctx_live forms a two-state FSM:
  - IDLE → LIVE on BUBBLE or HOLD.
  - LIVE → IDLE on PASS or FLUSH.
  - LIVE stays LIVE across repeated BUBBLE/HOLD cycles, with ctx_o re-captured every cycle.
- Flush together with any stall pattern: flush wins. Any in-progress context is discarded.
- S = 0 with N = 1 is a caller error. The block still performs PASS.
- Counters: bubble_cnt increments on each BUBBLE cycle and hold_cnt on each HOLD cycle. Both saturate at all-ones and never wrap.

## Timing
- Latency from input to output is 1 cycle in PASS.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- ctx_o loaded at edge k is visible to the execute unit during cycle k+1, which closes the multi-cycle feedback loop with 1-cycle turnaround.
- Counters update on the same edge as the mode they count.

## Configuration
- PIPE_STAGE_PERF_EN defined: the bubble_cnt and hold_cnt counters are built as described above.
- PIPE_STAGE_PERF_EN undefined: the ports still exist but are tied to 0, and no counter flops are synthesised. The interface is identical in both builds.

## Structure
- Shared package pipe_pkg holds:
  - the Stop/NoStop constants;
  - the mode enum {MODE_FLUSH, MODE_PASS, MODE_BUBBLE, MODE_HOLD};
  - the default DATA_W and CTX_W constants for the classic MIPS stages.
- Mode decode is a small combinational function in the package, shared with the other stage registers.
- One sub-module, pipe_sat_cnt (width PERF_W, inc, clk, rst, count), is instantiated twice under PIPE_STAGE_PERF_EN.

## Test plan
- Reset asserted mid-stream with out_data = 0xAB… → all outputs and counters go to 0 before the next clk edge; ctx_live = 0.
- PASS: in_valid = 1, in_data = 0x1234 with stall = 000000 → out_valid = 1 and out_data = 0x1234 one cycle later; ctx_o = 0.
- Multi-cycle op (STAGE_IDX = 3): stall = 001000 for 2 cycles with ctx_i = 0x1 then 0x2 → out_valid = 0, out_data = NOP_VALUE, ctx_o = 0x2, ctx_live = 1, bubble_cnt = 2. Next cycle with stall = 0 → ctx_o = 0, ctx_live = 0.
- HOLD: stall = 011000 for 3 cycles after 0x55 was captured → out_data stays 0x55, out_valid stays 1, hold_cnt = 3.
- Flush together with stall = 011000 while ctx_live = 1 → out_valid = 0, ctx_o = 0, ctx_live = 0, and neither counter increments.
- PERF_W = 4 with 20 BUBBLE cycles → bubble_cnt stops at 15. With PIPE_STAGE_PERF_EN undefined → both counters read 0 throughout.
